// File: rtl/coin_pkg.sv
// Shared types and constants for the coin/vend controller.
// Segment glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package coin_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } state_t;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/seg7_hex.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg7_hex
   import coin_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_0;
      case (i_hex)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = SEG_A;
         4'hB: o_seg = SEG_B;
         4'hC: o_seg = SEG_C;
         4'hD: o_seg = SEG_D;
         4'hE: o_seg = SEG_E;
         4'hF: o_seg = SEG_F;
         default: o_seg = SEG_0;
      endcase
   end

endmodule

// File: rtl/coin_vend_ctrl.sv
// Coin accumulator with saturating cap, fixed-price vend and unit-by-unit change return.
// Credit is shown on an active-low 7-segment display.
module coin_vend_ctrl
   import coin_pkg::*;
#(
   parameter int unsigned BITS       = 4,
   parameter int unsigned MAX_CREDIT = 10,
   parameter int unsigned VAL_LO     = 1,
   parameter int unsigned VAL_HI     = 5,
   parameter int unsigned PRICE      = 3
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            moneda100,
   input  logic            moneda500,
   input  logic            buy,
   input  logic            cancel,
   output logic [BITS-1:0] result,
   output logic [6:0]      display,
   output logic            vend,
   output logic            change_pulse,
   output logic            reject,
   output logic            busy
);

   localparam logic [BITS:0]   C_MAX     = (BITS+1)'(MAX_CREDIT);
   localparam logic [BITS:0]   C_VAL_LO  = (BITS+1)'(VAL_LO);
   localparam logic [BITS:0]   C_VAL_HI  = (BITS+1)'(VAL_HI);
   localparam logic [BITS:0]   C_PRICE_W = (BITS+1)'(PRICE);
   localparam logic [BITS-1:0] C_PRICE   = (BITS)'(PRICE);
   localparam logic [BITS-1:0] C_ONE     = (BITS)'(1);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [BITS-1:0] r_result;
   logic [BITS-1:0] w_result_nxt;
   logic            r_reject;
   logic            w_reject_nxt;

   logic            r_m100_q;
   logic            r_m500_q;
   logic            r_buy_q;
   logic            r_cancel_q;

   logic            w_ev100;
   logic            w_ev500;
   logic            w_evbuy;
   logic            w_evcancel;
   logic            w_any_coin;
   logic [BITS:0]   w_res_ext;
   logic [BITS:0]   w_sum_lo;
   logic [BITS:0]   w_sum_hi;
   logic [3:0]      w_nibble;

   // History resets high so a level already present at reset release is not an event.
   assign w_ev100    = moneda100 & ~r_m100_q;
   assign w_ev500    = moneda500 & ~r_m500_q;
   assign w_evbuy    = buy       & ~r_buy_q;
   assign w_evcancel = cancel    & ~r_cancel_q;
   assign w_any_coin = w_ev100 | w_ev500;

   assign w_res_ext = {1'b0, r_result};
   assign w_sum_lo  = w_res_ext + C_VAL_LO;
   assign w_sum_hi  = w_res_ext + C_VAL_HI;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_result   <= '0;
         r_reject   <= 1'b0;
         r_m100_q   <= 1'b1;
         r_m500_q   <= 1'b1;
         r_buy_q    <= 1'b1;
         r_cancel_q <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_result   <= w_result_nxt;
         r_reject   <= w_reject_nxt;
         r_m100_q   <= moneda100;
         r_m500_q   <= moneda500;
         r_buy_q    <= buy;
         r_cancel_q <= cancel;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_result_nxt = r_result;
      w_reject_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_evcancel && (r_result != '0)) begin
               w_state_nxt  = CHANGE;
               w_reject_nxt = w_any_coin;
            end else if (w_evbuy && (w_res_ext >= C_PRICE_W)) begin
               w_result_nxt = r_result - C_PRICE;
               w_state_nxt  = VEND;
               w_reject_nxt = w_any_coin;
            end else if (w_ev500) begin
               // High coin wins the edge; a simultaneous low coin is always bounced.
               if (w_sum_hi <= C_MAX) begin
                  w_result_nxt = w_sum_hi[BITS-1:0];
               end else begin
                  w_reject_nxt = 1'b1;
               end
               if (w_ev100) begin
                  w_reject_nxt = 1'b1;
               end
            end else if (w_ev100) begin
               if (w_sum_lo <= C_MAX) begin
                  w_result_nxt = w_sum_lo[BITS-1:0];
               end else begin
                  w_reject_nxt = 1'b1;
               end
            end
         end
         VEND: begin
            w_reject_nxt = w_any_coin;
            w_state_nxt  = (r_result != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            w_reject_nxt = w_any_coin;
            if (r_result != '0) begin
               w_result_nxt = r_result - C_ONE;
            end
            if (r_result <= C_ONE) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign result       = r_result;
   assign vend         = (r_state == VEND);
   assign change_pulse = (r_state == CHANGE);
   assign busy         = (r_state != IDLE);
   assign reject       = r_reject;
   assign w_nibble     = 4'(r_result);

   seg7_hex u_seg7_hex (
      .i_hex (w_nibble),
      .o_seg (display)
   );

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// Directed table-driven bench for coin_vend_ctrl, plus a hand-written async-reset sequence.
module tb_coin_vend_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       m100 = 1'b0;
   logic       m500 = 1'b0;
   logic       buy_i = 1'b0;
   logic       cancel_i = 1'b0;
   logic [3:0] result;
   logic [6:0] display;
   logic       vend;
   logic       change_pulse;
   logic       reject;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   coin_vend_ctrl #(
      .BITS       (4),
      .MAX_CREDIT (10),
      .VAL_LO     (1),
      .VAL_HI     (5),
      .PRICE      (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .moneda100    (m100),
      .moneda500    (m500),
      .buy          (buy_i),
      .cancel       (cancel_i),
      .result       (result),
      .display      (display),
      .vend         (vend),
      .change_pulse (change_pulse),
      .reject       (reject),
      .busy         (busy)
   );

   typedef struct {
      logic        m100;
      logic        m500;
      logic        buy;
      logic        cancel;
      int unsigned res;
      logic        vend;
      logic        chg;
      logic        rej;
      logic        busy;
   } vec_t;

   vec_t       vq[$];
   logic [6:0] seg_tab [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic a, input logic b, input logic c, input logic d,
                      input int unsigned r, input logic v, input logic ch,
                      input logic rj, input logic bz);
      vec_t x;
      x.m100 = a; x.m500 = b; x.buy = c; x.cancel = d;
      x.res = r; x.vend = v; x.chg = ch; x.rej = rj; x.busy = bz;
      vq.push_back(x);
   endtask

   task automatic check_all(input string tag, input int unsigned r, input logic v,
                            input logic ch, input logic rj, input logic bz);
      chk({tag, ".result"},  {28'd0, result}, r);
      chk({tag, ".display"}, {25'd0, display}, {25'd0, seg_tab[r[3:0]]});
      chk({tag, ".vend"},    {31'd0, vend}, {31'd0, v});
      chk({tag, ".change"},  {31'd0, change_pulse}, {31'd0, ch});
      chk({tag, ".reject"},  {31'd0, reject}, {31'd0, rj});
      chk({tag, ".busy"},    {31'd0, busy}, {31'd0, bz});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

      // Test 1: single pulses, then a level held for five cycles
      add(0,0,0,0, 0, 0,0,0,0);
      add(1,0,0,0, 1, 0,0,0,0);
      add(0,0,0,0, 1, 0,0,0,0);
      add(1,0,0,0, 2, 0,0,0,0);
      add(0,0,0,0, 2, 0,0,0,0);
      add(1,0,0,0, 3, 0,0,0,0);
      add(0,0,0,0, 3, 0,0,0,0);
      for (int i = 0; i < 5; i++) add(1,0,0,0, 4, 0,0,0,0);
      add(0,0,0,0, 4, 0,0,0,0);
      // Test 2a: climb to 6, oversize coin refused
      add(1,0,0,0, 5, 0,0,0,0);
      add(0,0,0,0, 5, 0,0,0,0);
      add(1,0,0,0, 6, 0,0,0,0);
      add(0,0,0,0, 6, 0,0,0,0);
      add(0,1,0,0, 6, 0,0,1,0);
      add(0,0,0,0, 6, 0,0,0,0);
      // Test 3: 7, buy, vend then four change cycles
      add(1,0,0,0, 7, 0,0,0,0);
      add(0,0,0,0, 7, 0,0,0,0);
      add(0,0,1,0, 4, 1,0,0,1);
      add(0,0,0,0, 4, 0,1,0,1);
      add(0,0,0,0, 3, 0,1,0,1);
      add(0,0,0,0, 2, 0,1,0,1);
      add(0,0,0,0, 1, 0,1,0,1);
      add(0,0,0,0, 0, 0,0,0,0);
      // Test 4: buy below price ignored, cancel refunds 2, cancel at 0 ignored
      add(1,0,0,0, 1, 0,0,0,0);
      add(0,0,0,0, 1, 0,0,0,0);
      add(1,0,0,0, 2, 0,0,0,0);
      add(0,0,0,0, 2, 0,0,0,0);
      add(0,0,1,0, 2, 0,0,0,0);
      add(0,0,0,0, 2, 0,0,0,0);
      add(0,0,0,1, 2, 0,1,0,1);
      add(0,0,0,0, 1, 0,1,0,1);
      add(0,0,0,0, 0, 0,0,0,0);
      add(0,0,0,1, 0, 0,0,0,0);
      add(0,0,0,0, 0, 0,0,0,0);
      // Test 5: both coins at once, buy+cancel, coin during change
      add(1,1,0,0, 5, 0,0,1,0);
      add(0,0,0,0, 5, 0,0,0,0);
      add(0,0,1,1, 5, 0,1,0,1);
      add(0,0,0,0, 4, 0,1,0,1);
      add(1,0,0,0, 3, 0,1,1,1);
      add(0,0,0,0, 2, 0,1,0,1);
      add(0,0,0,0, 1, 0,1,0,1);
      add(0,0,0,0, 0, 0,0,0,0);
      // Test 2b: 5 then exactly the cap, then a coin at the cap
      add(0,1,0,0, 5, 0,0,0,0);
      add(0,0,0,0, 5, 0,0,0,0);
      add(0,1,0,0, 10, 0,0,0,0);
      add(0,0,0,0, 10, 0,0,0,0);
      add(1,0,0,0, 10, 0,0,1,0);
      add(0,0,0,0, 10, 0,0,0,0);
      // Lead-in to test 6: vend from 10 and drain to 3
      add(0,0,1,0, 7, 1,0,0,1);
      add(0,0,0,0, 7, 0,1,0,1);
      add(0,0,0,0, 6, 0,1,0,1);
      add(0,0,0,0, 5, 0,1,0,1);
      add(0,0,0,0, 4, 0,1,0,1);
      add(0,0,0,0, 3, 0,1,0,1);

      #1 rst = 1'b1;
      #2;
      check_all("reset", 0, 0, 0, 0, 0);
      #10 rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         m100 = vq[i].m100; m500 = vq[i].m500;
         buy_i = vq[i].buy; cancel_i = vq[i].cancel;
         tick();
         check_all($sformatf("v%0d", i), vq[i].res, vq[i].vend, vq[i].chg,
                   vq[i].rej, vq[i].busy);
      end

      // Test 6: async reset mid-CHANGE, coin held high across release
      #2;
      m100 = 1'b1;
      rst  = 1'b1;
      #1;
      check_all("rst_async", 0, 0, 0, 0, 0);
      tick();
      check_all("rst_held", 0, 0, 0, 0, 0);
      #2 rst = 1'b0;
      tick();
      check_all("post_rst0", 0, 0, 0, 0, 0);
      tick();
      check_all("post_rst1", 0, 0, 0, 0, 0);
      m100 = 1'b0;
      tick();
      check_all("post_drop", 0, 0, 0, 0, 0);
      m100 = 1'b1;
      tick();
      check_all("post_rise", 1, 0, 0, 0, 0);
      m100 = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/coin_vend_ctrl.md
Name: coin_vend_ctrl

Overview:
Parametrised coin-accumulator and vend controller for the vending-machine lab datapath.
- Counts two coin denominations up to a saturating cap and rejects coins that would overflow it.
- Executes a purchase at a fixed price, then returns the remaining credit as one change pulse per unit.
- Drives an active-low 7-segment display of the current credit. Sits between the debounced coin/button inputs and the board LEDs/display.

Parameters:
- BITS, 4, credit register width.
- MAX_CREDIT, 10, credit cap in units (1 unit = 100); must be < 2**BITS.
- VAL_LO, 1, units added by moneda100.
- VAL_HI, 5, units added by moneda500.
- PRICE, 3, units deducted per vend; 1 <= PRICE <= MAX_CREDIT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- moneda100  in  1  low-denomination coin level, synchronous to clk.
- moneda500  in  1  high-denomination coin level, synchronous to clk.
- buy  in  1  purchase request level.
- cancel  in  1  refund request level.
- result  out  BITS  current credit.
- display  out  7  active-low segments {g..a} of result, hex glyphs 0–F.
- vend  out  1  one-cycle dispense pulse.
- change_pulse  out  1  high one cycle per unit returned.
- reject  out  1  one-cycle coin-reject pulse.
- busy  out  1  high while not IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high (rst). On rst, immediately and without a clock edge:
  - state=IDLE, result=0, display=7'b1000000, vend/change_pulse/reject/busy=0.
  - Edge-detect history registers for moneda100, moneda500, buy and cancel reset to 1, so an input held high across reset release is not counted.
- Edge detection: an event is input=1 at edge k with input=0 at edge k-1. A held level yields exactly one event.
- FSM states: IDLE, VEND, CHANGE.
  - vend = (state==VEND).
  - change_pulse = (state==CHANGE).
  - busy = (state!=IDLE).
- IDLE priority, highest first:
  1. cancel event with result>0: go to CHANGE at edge k, result unchanged.
  2. buy event with result>=PRICE: result -= PRICE at edge k, go to VEND.
  3. buy event with result<PRICE: ignored, no output.
  4. Coin events.
  - cancel with result==0 is ignored.
- Coin rules (IDLE only):
  - moneda500 event is evaluated before moneda100.
  - Sums are computed at BITS+1 width; a coin is accepted only if result+value <= MAX_CREDIT.
  - Accepted coin: result updates at edge k.
  - Refused coin: result unchanged, reject=1 for the cycle after edge k.
  - Simultaneous moneda500 and moneda100 events: moneda500 is evaluated (accept or refuse), and moneda100 always raises reject.
  - Any coin event in VEND/CHANGE, or coincident with a buy/cancel that is acted on, raises reject and leaves credit unchanged.
  - reject is a single-cycle pulse regardless of how many coins were refused.
- VEND: lasts exactly one cycle. Next state is CHANGE if result>0, else IDLE.
- CHANGE: at every edge result -= 1. When result==1 the same edge goes to IDLE. change_pulse is therefore high for exactly N cycles, where N is the credit on entry.
- buy/cancel events in VEND/CHANGE are discarded.
- display: combinational decode of result, updating in the same cycle as result.

Decomposition:
- Package coin_pkg:
  - state_t enum {IDLE, VEND, CHANGE}.
  - SEG_* active-low glyph constants for 0–F, with SEG_0=7'b1000000.
- Sub-module seg7_hex: combinational 4-bit to 7-segment decoder, instantiated once on result. It is the only sub-module; the FSM, edge detection and credit arithmetic stay in coin_vend_ctrl.

Test Plan:
1. Reset, then three separate moneda100 pulses, then moneda100 held 5 cycles -> result 3 then 4 (held level counts once); display 7'b0110000 then 7'b0011001.
2. result=6, moneda500 pulse -> reject=1 one cycle, result stays 6. result=5, moneda500 -> result=10, display 7'b0001000, no reject.
3. result=7, buy pulse -> vend=1 one cycle with result=4; then change_pulse for 4 consecutive cycles (result 3,2,1,0); busy high across VEND and CHANGE, then IDLE.
4. result=2, buy -> no vend, result 2. Then cancel -> exactly 2 change_pulse cycles, result 0. Then cancel at 0 -> nothing.
5. result=0, moneda100 and moneda500 events same edge -> result=5, reject=1. Then buy+cancel same edge -> no vend, 5 change pulses. A coin inserted during CHANGE -> reject, count unaffected.
6. rst asserted mid-CHANGE at result=3 between clock edges -> all outputs at reset values immediately. moneda100 held high through rst release -> not counted until it drops and rises again.
